// File: rtl/dac_sample_scheduler.sv
// Paces host PCM samples into the filter/DAC datapath: one sample every osr_i+1 cycles,
// with a small FIFO, priming, underrun, mute and enable sequencing.
module dac_sample_scheduler #(
    parameter int BW    = 16,
    parameter int DEPTH = 4,
    parameter int OSR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     mute_i,
    input  logic [OSR_W-1:0]         osr_i,
    input  logic [BW-1:0]            s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    output logic [BW-1:0]            dac_sample_o,
    output logic                     sample_tick_o,
    output logic                     underrun_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [1:0]               state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    state_t           state;
    logic [OSR_W-1:0] cnt;
    logic [BW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             push, pop, slot, empty;

    assign s_ready_o = (level_o != LW'(DEPTH));
    assign empty     = (level_o == '0);
    assign push      = s_valid_i && s_ready_o;
    // A slot is abandoned when en_i drops in the same cycle.
    assign slot      = (state == RUN) && en_i && (cnt == '0);
    assign pop       = slot && !empty;
    assign state_o   = state;

    always_ff @(posedge clk) begin
        if (push && !rst_i)
            mem[wptr] <= s_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            wptr          <= '0;
            rptr          <= '0;
            level_o       <= '0;
            dac_sample_o  <= '0;
            sample_tick_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            sample_tick_o <= 1'b0;
            underrun_o    <= 1'b0;

            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   level_o <= level_o + LW'(1);
                2'b01:   level_o <= level_o - LW'(1);
                default: ;
            endcase

            case (state)
                IDLE: begin
                    cnt          <= '0;
                    dac_sample_o <= '0;
                    if (en_i) state <= PRIME;
                end
                PRIME: begin
                    if (!en_i) begin
                        state        <= IDLE;
                        dac_sample_o <= '0;
                    end else if (level_o >= LW'(2)) begin
                        state <= RUN;
                        cnt   <= osr_i;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        dac_sample_o <= '0;
                    end else if (cnt == '0) begin
                        cnt <= osr_i;
                        if (!empty) begin
                            dac_sample_o  <= mute_i ? '0 : mem[rptr];
                            sample_tick_o <= 1'b1;
                        end else begin
                            if (mute_i) dac_sample_o <= '0;
                            underrun_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - OSR_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    dac_sample_o <= '0;
                end
            endcase
        end
    end
endmodule
